oisc_bus_arbiter: RTL and testbench
===================================

OISC_BUS_ARBITER -- requirements
Module: oisc_bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16: the maximum number of BUSY cycles spent waiting for s_ready; legal range 2..255.
REQ-002 The block SHALL have parameter ERR_DATA, default 16'hFFFF: the read data returned on a timed-out transaction.
REQ-003 Port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port m0_req, input, 1: master 0 transaction request.
REQ-006 Port m0_we, input, 1: master 0 write enable (1 = write, 0 = read).
REQ-007 Port m0_addr, input, 16: master 0 address.
REQ-008 Port m0_wdata, input, 16: master 0 write data.
REQ-009 Port m0_rdata, output, 16: master 0 read data.
REQ-010 Port m0_ack, output, 1: master 0 completion pulse.
REQ-011 Ports m1_req, m1_we, m1_addr, m1_wdata, m1_rdata and m1_ack SHALL be identical to the master 0 ports (REQ-005..REQ-010), for master 1.
REQ-012 Port s_valid, output, 1: shared-bus transaction strobe.
REQ-013 Port s_we, output, 1: shared-bus write enable.
REQ-014 Port s_addr, output, 16: shared-bus address.
REQ-015 Port s_wdata, output, 16: shared-bus write data.
REQ-016 Port s_rdata, input, 16: read data from the target (memory, ALU or external).
REQ-017 Port s_ready, input, 1: target completion.
REQ-018 Port grant, output, 2: one-hot current bus owner; 2'b00 when idle.
REQ-019 Port bus_err, output, 1: timeout indication, pulsed together with ack.

Function
REQ-020 The block SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-021 In IDLE, when any mN_req=1, the block SHALL select a winner, latch that master's we, addr and wdata into internal registers, set grant to the winner, and move to BUSY.
- With a single requester, that requester wins.
- With both requesting, the master not served last wins (round-robin).
REQ-022 In BUSY, the block SHALL:
- hold s_valid=1;
- drive s_we, s_addr and s_wdata from the latched registers, stable for the whole of BUSY;
- increment a wait counter each cycle.
REQ-023 In BUSY with s_ready=1 sampled, the block SHALL move to DONE and capture s_rdata into the winner's rdata register (reads only). On writes, the winner's rdata SHALL be left unchanged.
REQ-024 In BUSY, when the wait counter reaches TIMEOUT-1 with s_ready=0, the block SHALL:
- move to DONE;
- load ERR_DATA into the winner's rdata on reads;
- flag the error for DONE.
REQ-025 In DONE, the block SHALL:
- assert the winner's mN_ack for exactly one cycle;
- assert bus_err in the same cycle if the transaction timed out;
- drive s_valid=0;
- record the winner as last-served;
- clear grant, the wait counter and the error flag;
- return to IDLE.
REQ-026 mN_rdata SHALL be held from the DONE cycle until that master's next completed read.
REQ-027 Minimum latency SHALL be: req sampled at edge 0; s_valid high in cycle 1; s_ready=1 in cycle 1 gives ack in cycle 2; next arbitration at the edge ending cycle 2. Throughput is one transaction per 3 cycles.
REQ-028 s_ready SHALL be ignored outside BUSY.
REQ-029 A master deasserting req mid-transaction SHALL NOT abort it; the transaction completes and ack still pulses.
REQ-030 Masters SHALL hold req, we, addr and wdata until ack. A req still high in the ack cycle SHALL be treated as a new request at the following IDLE evaluation.
REQ-031 The two ack outputs SHALL never be high in the same cycle.
REQ-032 A req arriving while the bus is BUSY or DONE SHALL wait, with no loss, until IDLE.

Reset
REQ-033 Asserting rst SHALL immediately force, without waiting for clk:
- state = IDLE;
- s_valid, s_we, m0_ack, m1_ack and bus_err = 0;
- grant = 2'b00;
- s_addr, s_wdata, m0_rdata and m1_rdata = 16'h0000;
- wait counter = 0;
- last-served = master 1, so master 0 wins the first tie.
REQ-034 Reset during BUSY SHALL abandon the transaction with no ack issued.
REQ-035 After rst deasserts, arbitration SHALL resume at the first clk edge.

Verification
REQ-036 Single read: m0 reads addr 16'h0108, target returns 16'h0001 with s_ready in the first BUSY cycle -> s_valid for exactly 1 cycle, m0_ack in cycle 2, m0_rdata = 16'h0001.
REQ-037 Tie: m0 and m1 request simultaneously after reset -> m0 served first, then m1; alternation continues over 4 back-to-back pairs; acks never overlap.
REQ-038 Write: m1 writes 16'h00AB to 16'h8000 -> s_we=1, s_addr=16'h8000, s_wdata=16'h00AB stable while s_valid; m1_rdata unchanged after ack.
REQ-039 Timeout: m0 reads, s_ready held low -> m0_ack and bus_err both high in the same single cycle after TIMEOUT BUSY cycles, m0_rdata = 16'hFFFF.
REQ-040 Reset mid-BUSY: assert rst between clk edges -> s_valid drops immediately, no ack issued; after release, a pending m1 request is served normally.
REQ-041 Early req drop: m0 drops req in BUSY -> target sees the full transaction, m0_ack still pulses once.

Source files
------------

// File: rtl/oisc_bus_arbiter.sv
// Two-master round-robin arbiter for the OISC shared bus.
// Each transaction runs IDLE -> BUSY -> DONE; a stalled target is cut off after TIMEOUT cycles.
module oisc_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic [15:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic [15:0] m1_rdata,
    output logic        m1_ack,
    output logic        s_valid,
    output logic        s_we,
    output logic [15:0] s_addr,
    output logic [15:0] s_wdata,
    input  logic [15:0] s_rdata,
    input  logic        s_ready,
    output logic [1:0]  grant,
    output logic        bus_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [7:0]  wait_cnt;
    logic        err_q;
    logic        last_m1;
    logic        pick_m1;
    logic        timeout_hit;

    // m1 wins when alone, or on a tie when m0 was served last.
    always_comb begin
        pick_m1     = m1_req & (~m0_req | ~last_m1);
        timeout_hit = (wait_cnt == WAIT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= 2'b00;
            we_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            m0_rdata <= 16'h0000;
            m1_rdata <= 16'h0000;
            wait_cnt <= 8'd0;
            err_q    <= 1'b0;
            last_m1  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        grant    <= pick_m1 ? 2'b10 : 2'b01;
                        we_q     <= pick_m1 ? m1_we : m0_we;
                        addr_q   <= pick_m1 ? m1_addr : m0_addr;
                        wdata_q  <= pick_m1 ? m1_wdata : m0_wdata;
                        wait_cnt <= 8'd0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_ready) begin
                        if (!we_q) begin
                            if (grant[1]) m1_rdata <= s_rdata;
                            else          m0_rdata <= s_rdata;
                        end
                        state <= DONE;
                    end else if (timeout_hit) begin
                        if (!we_q) begin
                            if (grant[1]) m1_rdata <= ERR_DATA;
                            else          m0_rdata <= ERR_DATA;
                        end
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    last_m1  <= grant[1];
                    grant    <= 2'b00;
                    wait_cnt <= 8'd0;
                    err_q    <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_valid = (state == BUSY);
        s_we    = we_q & s_valid;
        s_addr  = addr_q;
        s_wdata = wdata_q;
        m0_ack  = (state == DONE) & grant[0];
        m1_ack  = (state == DONE) & grant[1];
        bus_err = (state == DONE) & err_q;
    end

endmodule

// File: tb/tb_oisc_bus_arbiter.sv
// Directed bench for oisc_bus_arbiter: a scoreboard queue drives the target model
// and is checked on every ack.
module tb_oisc_bus_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [15:0] m0_addr = 16'h0, m0_wdata = 16'h0;
    logic [15:0] m0_rdata;
    logic        m0_ack;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [15:0] m1_addr = 16'h0, m1_wdata = 16'h0;
    logic [15:0] m1_rdata;
    logic        m1_ack;
    logic        s_valid, s_we;
    logic [15:0] s_addr, s_wdata;
    logic [15:0] s_rdata = 16'h0;
    logic        s_ready = 1'b0;
    logic [1:0]  grant;
    logic        bus_err;

    oisc_bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(16'hFFFF)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .s_valid(s_valid), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] ret;
        int          delay;
        logic        hang;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } ent_t;

    ent_t        q[$];
    logic [15:0] mdl_rdata [2];
    int          total = 0;
    int          bad = 0;
    int          bcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic m, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] ret,
                        input int delay, input logic hang);
        ent_t e;
        if (!we) mdl_rdata[m] = hang ? 16'hFFFF : ret;
        e.m = m; e.we = we; e.addr = addr; e.wdata = wdata; e.ret = ret;
        e.delay = delay; e.hang = hang;
        e.exp_rdata = mdl_rdata[m];
        e.exp_err = hang;
        q.push_back(e);
    endtask

    task automatic set_m(input logic m, input logic req, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (m) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic wait_ack(input logic m);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m ? m1_ack : m0_ack) return;
        end
        chk("ack_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic xact(input logic m, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] ret,
                        input int delay, input logic hang, input logic drop_early);
        push(m, we, addr, wdata, ret, delay, hang);
        set_m(m, 1'b1, we, addr, wdata);
        if (drop_early) begin
            for (int i = 0; i < 20 && !s_valid; i++) @(negedge clk);
            chk("early_drop_busy", 32'(s_valid), 32'd1);
            set_m(m, 1'b0, we, addr, wdata);
        end
        wait_ack(m);
        set_m(m, 1'b0, ~we, ~addr, ~wdata);
    endtask

    // Target model plus scoreboard checker; s_ready is driven high outside BUSY on purpose.
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            bcnt = 0;
            s_ready = 1'b0;
        end else begin
            if (m0_ack && m1_ack) chk("ack_overlap", 32'd1, 32'd0);
            if (m0_ack || m1_ack) begin
                if (q.size() == 0) begin
                    chk("spurious_ack", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("ack_master", 32'(m1_ack), 32'(e.m));
                    chk("rdata", 32'(e.m ? m1_rdata : m0_rdata), 32'(e.exp_rdata));
                    chk("bus_err", 32'(bus_err), 32'(e.exp_err));
                    chk("busy_cycles", 32'(bcnt), e.hang ? 32'(TO) : 32'(e.delay + 1));
                end
                bcnt = 0;
            end else if (bus_err) begin
                chk("bus_err_without_ack", 32'd1, 32'd0);
            end
            if (s_valid) begin
                if (q.size() == 0) begin
                    chk("valid_without_request", 32'd1, 32'd0);
                    s_ready = 1'b1;
                end else begin
                    chk("s_we", 32'(s_we), 32'(q[0].we));
                    chk("s_addr", 32'(s_addr), 32'(q[0].addr));
                    if (q[0].we) chk("s_wdata", 32'(s_wdata), 32'(q[0].wdata));
                    chk("grant", 32'(grant), q[0].m ? 32'd2 : 32'd1);
                    s_rdata = q[0].ret;
                    s_ready = !q[0].hang && (bcnt >= q[0].delay);
                end
                bcnt++;
            end else begin
                s_ready = 1'b1;
                s_rdata = 16'hDEAD;
            end
        end
    end

    initial begin
        int c0, c1;
        mdl_rdata[0] = 16'h0;
        mdl_rdata[1] = 16'h0;

        // Reset asserted before any clock edge: outputs must clear asynchronously.
        #1 rst = 1'b1;
        #3;
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_s_we", 32'(s_we), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_acks", 32'({m0_ack, m1_ack, bus_err}), 32'd0);
        chk("rst_s_addr", 32'(s_addr), 32'd0);
        chk("rst_s_wdata", 32'(s_wdata), 32'd0);
        chk("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // Single read with immediate ready.
        xact(1'b0, 1'b0, 16'h0108, 16'h0, 16'h0001, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("single_read_idle", 32'({s_valid, grant}), 32'd0);

        // Tie after reset: m0 first, then strict alternation over 4 pairs.
        @(negedge clk) rst = 1'b1;
        mdl_rdata[0] = 16'h0;
        mdl_rdata[1] = 16'h0;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 8; i++)
            push(1'(i % 2), 1'b0, (i % 2) ? 16'h2000 : 16'h1000, 16'h0, 16'(16'h1000 + i), i % 3, 1'b0);
        set_m(1'b0, 1'b1, 1'b0, 16'h1000, 16'h0);
        set_m(1'b1, 1'b1, 1'b0, 16'h2000, 16'h0);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 200 && (c0 < 4 || c1 < 4); i++) begin
            @(negedge clk);
            if (m0_ack) begin
                c0++;
                if (c0 == 4) m0_req = 1'b0;
            end
            if (m1_ack) begin
                c1++;
                if (c1 == 4) m1_req = 1'b0;
            end
        end
        chk("tie_ack_count", 32'({c0[7:0], c1[7:0]}), 32'h0404);

        // Write from m1: bus fields checked every BUSY cycle, m1_rdata must not move.
        xact(1'b1, 1'b1, 16'h8000, 16'h00AB, 16'h1234, 2, 1'b0, 1'b0);

        // Timeout on a read from m0.
        xact(1'b0, 1'b0, 16'h0200, 16'h0, 16'h0, 0, 1'b1, 1'b0);

        // m0 drops req during BUSY; transaction still completes.
        xact(1'b0, 1'b0, 16'h0300, 16'h0, 16'h4242, 3, 1'b0, 1'b1);
        repeat (4) @(negedge clk);

        // Reset between edges while BUSY, then a still-pending m1 request is served.
        push(1'b1, 1'b0, 16'h0400, 16'h0, 16'h0, 0, 1'b1);
        set_m(1'b1, 1'b1, 1'b0, 16'h0400, 16'h0);
        for (int i = 0; i < 20 && !s_valid; i++) @(negedge clk);
        chk("pre_reset_busy", 32'(s_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_s_valid", 32'(s_valid), 32'd0);
        chk("midrst_acks", 32'({m0_ack, m1_ack, bus_err}), 32'd0);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
        q.delete();
        mdl_rdata[0] = 16'h0;
        mdl_rdata[1] = 16'h0;
        @(negedge clk) rst = 1'b0;
        xact(1'b1, 1'b0, 16'h0400, 16'h0, 16'h5555, 1, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
